// File: rtl/fetch_stage_ctrl_if.sv
// Signal bundle between the fetch-stage controller and its hazard/debug neighbours.
// The slave side is the fetch stage; the master side drives requests and observes IF/ID.
interface fetch_stage_ctrl_if #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned INSTR_WIDTH = 32
);
   logic                   i_enable;
   logic                   i_flush;
   logic                   i_not_load;
   logic                   i_jmp_stop_req;
   logic                   i_halt;
   logic                   i_jump_taken;
   logic [PC_WIDTH-1:0]    i_jump_addr;
   logic [INSTR_WIDTH-1:0] i_instruction;

   logic [PC_WIDTH-1:0]    o_pc;
   logic [INSTR_WIDTH-1:0] o_if_id_instr;
   logic [PC_WIDTH-1:0]    o_if_id_pc4;
   logic [4:0]             o_if_id_rs;
   logic [4:0]             o_if_id_rt;
   logic [4:0]             o_if_id_rd;
   logic [5:0]             o_if_id_op;
   logic [5:0]             o_if_id_funct;
   logic                   o_jmp_stop;
   logic                   o_draining;
   logic                   o_halted;

   modport slave (
      input  i_enable, i_flush, i_not_load, i_jmp_stop_req, i_halt,
             i_jump_taken, i_jump_addr, i_instruction,
      output o_pc, o_if_id_instr, o_if_id_pc4, o_if_id_rs, o_if_id_rt,
             o_if_id_rd, o_if_id_op, o_if_id_funct, o_jmp_stop,
             o_draining, o_halted
   );

   modport master (
      output i_enable, i_flush, i_not_load, i_jmp_stop_req, i_halt,
             i_jump_taken, i_jump_addr, i_instruction,
      input  o_pc, o_if_id_instr, o_if_id_pc4, o_if_id_rs, o_if_id_rt,
             o_if_id_rd, o_if_id_op, o_if_id_funct, o_jmp_stop,
             o_draining, o_halted
   );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// PC / IF-ID latch for the 5-stage MIPS core: applies stall, jump and halt
// requests and runs the halt drain sequence that reports pipeline completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_RUN    | normal fetch; honours stall, halt and taken jump
// S_DRAIN  | halt accepted; PC and IF/ID frozen while ID..WB empty out
// S_HALTED | drain complete; everything frozen until reset or flush
module fetch_stage_ctrl #(
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned INSTR_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] PC_RESET = '0,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   fetch_stage_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PC_WIDTH-1:0]    pc4_q, pc4_d;
   logic                   jmp_stop_q, jmp_stop_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]    pc_plus4;
   logic                   draining, halted;

   assign pc_plus4 = pc_q + PC_WIDTH'(4);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= S_RUN;
         pc_q       <= PC_RESET;
         instr_q    <= '0;
         pc4_q      <= '0;
         jmp_stop_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         jmp_stop_q <= jmp_stop_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      jmp_stop_d = jmp_stop_q;
      cnt_d      = cnt_q;

      if (bus.i_flush) begin
         state_d    = S_RUN;
         pc_d       = PC_RESET;
         instr_d    = '0;
         pc4_d      = '0;
         jmp_stop_d = 1'b0;
         cnt_d      = '0;
      end else if (bus.i_enable) begin
         unique case (state_q)
            S_RUN: begin
               // jump-stop tracks the hazard unit even while stalled
               jmp_stop_d = bus.i_jmp_stop_req;
               if (!bus.i_not_load) begin
                  if (bus.i_halt) begin
                     state_d = S_DRAIN;
                     instr_d = '0;
                     pc4_d   = '0;
                     cnt_d   = '0;
                  end else if (bus.i_jump_taken) begin
                     pc_d    = bus.i_jump_addr;
                     instr_d = '0;
                     pc4_d   = '0;
                  end else begin
                     pc_d    = pc_plus4;
                     instr_d = bus.i_instruction;
                     pc4_d   = pc_plus4;
                  end
               end
            end
            S_DRAIN: begin
               jmp_stop_d = 1'b0;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_HALTED;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_HALTED: begin
               jmp_stop_d = 1'b0;
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   always_comb begin
      draining = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         S_DRAIN:  draining = 1'b1;
         S_HALTED: halted   = 1'b1;
         default:  ;
      endcase
   end

   assign bus.o_pc          = pc_q;
   assign bus.o_if_id_instr = instr_q;
   assign bus.o_if_id_pc4   = pc4_q;
   assign bus.o_if_id_op    = instr_q[31:26];
   assign bus.o_if_id_rs    = instr_q[25:21];
   assign bus.o_if_id_rt    = instr_q[20:16];
   assign bus.o_if_id_rd    = instr_q[15:11];
   assign bus.o_if_id_funct = instr_q[5:0];
   assign bus.o_jmp_stop    = jmp_stop_q;
   assign bus.o_draining    = draining;
   assign bus.o_halted      = halted;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: a reference model pushes expected
// IF-stage state per edge, popped and compared just after the edge.
module tb_fetch_stage_ctrl;

   localparam int DC = 4;

   logic clk = 1'b0;
   logic rst;
   logic use_const;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   fetch_stage_ctrl_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

   fetch_stage_ctrl #(
      .PC_WIDTH(32), .INSTR_WIDTH(32), .PC_RESET(32'h0), .DRAIN_CYCLES(DC)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   function automatic logic [31:0] mem_word(input logic uc, input logic [31:0] a);
      return uc ? 32'h2001_0005 : {6'h2B, a[25:0]};
   endfunction

   assign bus.i_instruction = mem_word(use_const, bus.o_pc);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        js;
      logic        dr;
      logic        ht;
   } exp_t;

   exp_t sb[$];

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_js;
   int          m_st;   // 0 run, 1 drain, 2 halted
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_js = 1'b0; m_st = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      if (bus.i_flush) begin
         model_reset();
      end else if (bus.i_enable) begin
         if (m_st == 1) begin
            m_js = 1'b0;
            m_cnt++;
            if (m_cnt == DC) m_st = 2;
         end else if (m_st == 2) begin
            m_js = 1'b0;
         end else begin
            m_js = bus.i_jmp_stop_req;
            if (bus.i_not_load) begin
               // hold
            end else if (bus.i_halt) begin
               m_st = 1; m_cnt = 0; m_instr = 32'h0; m_pc4 = 32'h0;
            end else if (bus.i_jump_taken) begin
               m_pc = bus.i_jump_addr; m_instr = 32'h0; m_pc4 = 32'h0;
            end else begin
               m_instr = mem_word(use_const, m_pc);
               m_pc4   = m_pc + 32'd4;
               m_pc    = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL sb_empty: got 0 entries, want 1");
         return;
      end
      e = sb.pop_front();
      chk("pc",       bus.o_pc, e.pc);
      chk("instr",    bus.o_if_id_instr, e.instr);
      chk("pc4",      bus.o_if_id_pc4, e.pc4);
      chk("jmp_stop", {31'b0, bus.o_jmp_stop}, {31'b0, e.js});
      chk("draining", {31'b0, bus.o_draining}, {31'b0, e.dr});
      chk("halted",   {31'b0, bus.o_halted}, {31'b0, e.ht});
      chk("op",       {26'b0, bus.o_if_id_op}, {26'b0, e.instr[31:26]});
      chk("rs",       {27'b0, bus.o_if_id_rs}, {27'b0, e.instr[25:21]});
      chk("rt",       {27'b0, bus.o_if_id_rt}, {27'b0, e.instr[20:16]});
      chk("rd",       {27'b0, bus.o_if_id_rd}, {27'b0, e.instr[15:11]});
      chk("funct",    {26'b0, bus.o_if_id_funct}, {26'b0, e.instr[5:0]});
   endtask

   task automatic cycle();
      exp_t e;
      model_edge();
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.js = m_js;
      e.dr = (m_st == 1); e.ht = (m_st == 2);
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      int k;
      rst = 1'b1;
      use_const = 1'b1;
      bus.i_enable = 1'b1; bus.i_flush = 1'b0; bus.i_not_load = 1'b0;
      bus.i_jmp_stop_req = 1'b0; bus.i_halt = 1'b0; bus.i_jump_taken = 1'b0;
      bus.i_jump_addr = 32'h0;
      #12;
      chk("rst_pc", bus.o_pc, 32'h0);
      chk("rst_instr", bus.o_if_id_instr, 32'h0);
      chk("rst_pc4", bus.o_if_id_pc4, 32'h0);
      chk("rst_halted", {31'b0, bus.o_halted}, 32'h0);
      chk("rst_draining", {31'b0, bus.o_draining}, 32'h0);
      model_reset();
      rst = 1'b0;

      // sequential fetch
      repeat (3) cycle();
      chk("seq_pc", bus.o_pc, 32'd12);
      chk("seq_instr", bus.o_if_id_instr, 32'h2001_0005);
      chk("seq_pc4", bus.o_if_id_pc4, 32'd12);
      chk("seq_rt", {27'b0, bus.o_if_id_rt}, 32'd1);

      // stall at pc=8
      bus.i_flush = 1'b1; cycle(); bus.i_flush = 1'b0;
      repeat (2) cycle();
      chk("stall_start_pc", bus.o_pc, 32'd8);
      bus.i_not_load = 1'b1; bus.i_jmp_stop_req = 1'b1; cycle();
      chk("stall_js1", {31'b0, bus.o_jmp_stop}, 32'd1);
      chk("stall_pc1", bus.o_pc, 32'd8);
      bus.i_jmp_stop_req = 1'b0; cycle();
      chk("stall_js2", {31'b0, bus.o_jmp_stop}, 32'd0);
      chk("stall_pc2", bus.o_pc, 32'd8);
      bus.i_not_load = 1'b0;

      // branch sequence
      use_const = 1'b0;
      bus.i_jmp_stop_req = 1'b1; bus.i_not_load = 1'b1; cycle();
      chk("br_js", {31'b0, bus.o_jmp_stop}, 32'd1);
      bus.i_jmp_stop_req = 1'b0; bus.i_not_load = 1'b0;
      bus.i_jump_taken = 1'b1; bus.i_jump_addr = 32'h40; cycle();
      chk("br_pc", bus.o_pc, 32'h40);
      chk("br_nop", bus.o_if_id_instr, 32'h0);
      bus.i_jump_taken = 1'b0;
      cycle();
      chk("br_fetch", bus.o_if_id_instr, {6'h2B, 26'h40});
      cycle();

      // halt at 0x10 with jump noise
      bus.i_jump_taken = 1'b1; bus.i_jump_addr = 32'h10; cycle();
      bus.i_jump_taken = 1'b1; bus.i_halt = 1'b1; bus.i_jump_addr = 32'h80; cycle();
      chk("halt_dr", {31'b0, bus.o_draining}, 32'd1);
      chk("halt_pc", bus.o_pc, 32'h10);
      bus.i_halt = 1'b0;
      k = 0;
      while (k < 20 && !bus.o_halted) begin
         bus.i_jump_taken = ~bus.i_jump_taken;
         cycle();
         k++;
      end
      chk("halt_lat", k, 32'd4);
      chk("halt_pc_hold", bus.o_pc, 32'h10);
      bus.i_jump_taken = 1'b0;

      // flush in HALTED
      bus.i_flush = 1'b1; cycle(); bus.i_flush = 1'b0;
      chk("flush_pc", bus.o_pc, 32'h0);
      chk("flush_halted", {31'b0, bus.o_halted}, 32'd0);

      // disabled cycles during drain
      repeat (2) cycle();
      bus.i_halt = 1'b1; cycle(); bus.i_halt = 1'b0;
      cycle();
      k = 1;
      bus.i_enable = 1'b0;
      repeat (3) begin cycle(); k++; end
      bus.i_enable = 1'b1;
      while (k < 20 && !bus.o_halted) begin
         cycle();
         k++;
      end
      chk("halt_lat_en", k, 32'd7);

      // async reset mid-drain
      bus.i_flush = 1'b1; cycle(); bus.i_flush = 1'b0;
      cycle();
      bus.i_halt = 1'b1; cycle(); bus.i_halt = 1'b0;
      cycle();
      #3 rst = 1'b1;
      #1;
      chk("arst_pc", bus.o_pc, 32'h0);
      chk("arst_instr", bus.o_if_id_instr, 32'h0);
      chk("arst_dr", {31'b0, bus.o_draining}, 32'd0);
      chk("arst_halted", {31'b0, bus.o_halted}, 32'd0);
      model_reset();
      #1 rst = 1'b0;

      // PC wrap
      bus.i_jump_taken = 1'b1; bus.i_jump_addr = 32'hFFFF_FFFC; cycle();
      bus.i_jump_taken = 1'b0; cycle();
      chk("wrap_pc", bus.o_pc, 32'h0);
      chk("wrap_pc4", bus.o_if_id_pc4, 32'h0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
